alu_seq_param: RTL
==================

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 SHALL expose parameter WIDTH, default 16, operand/result width (legal 8..64, even).
REQ-002 SHALL expose parameter SHW, default $clog2(WIDTH), number of B LSBs used as shift amount.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operands/opcode presented.
REQ-007 in_ready  output  1  block can accept an operation this cycle.
REQ-008 A  input  WIDTH  operand A, unsigned.
REQ-009 B  input  WIDTH  operand B, unsigned.
REQ-010 ALU_FUN  input  4  opcode.
REQ-011 out_valid  output  1  one-cycle pulse: new result on ALU_OUT/ALU_OUT_HI/flags.
REQ-012 ALU_OUT  output  WIDTH  result low word.
REQ-013 ALU_OUT_HI  output  WIDTH  product high word / division remainder, else 0.
REQ-014 carry_flag, arith_flag, logic_flag, cmp_flag, shift_flag, div_zero_flag  output  1 each  result class/status.

Function
REQ-015 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; otherwise inputs ignored.
REQ-016 Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR, 1010 EQ, 1011 GT, 1100 LT, 1101 SHR, 1110 SHL, 1111 NOP.
REQ-017 FSM states IDLE and DIV; in_ready=1 iff state=IDLE.
REQ-018 All non-DIV ops (and DIV with B=0) SHALL be single-cycle: outputs and out_valid register on the accepting edge; throughput one op per cycle.
REQ-019 ADD: ALU_OUT=(A+B) mod 2^WIDTH, carry_flag=carry-out; SUB: ALU_OUT=(A-B) mod 2^WIDTH, carry_flag=1 iff A<B.
REQ-020 MUL: full 2*WIDTH product, low word ALU_OUT, high word ALU_OUT_HI, carry_flag=1 iff high word nonzero.
REQ-021 DIV with B!=0: IDLE->DIV on accept; restoring shift-subtract, one quotient bit per cycle, exactly WIDTH cycles in DIV; quotient ALU_OUT, remainder ALU_OUT_HI, out_valid on the edge leaving DIV; DIV->IDLE.
REQ-022 DIV with B=0: no DIV state; ALU_OUT=all ones, ALU_OUT_HI=A, div_zero_flag=1, arith_flag=1.
REQ-023 Logic ops bitwise on WIDTH bits; logic_flag=1.
REQ-024 EQ: ALU_OUT=1 if A==B else 0; GT: 2 if A>B else 0; LT: 3 if A<B else 0; cmp_flag=1.
REQ-025 SHR/SHL: logical shift of A by B[SHW-1:0], zero fill; shift_flag=1.
REQ-026 arith_flag=1 for ADD/SUB/MUL/DIV; exactly one class flag high per non-NOP result; carry_flag and div_zero_flag 0 unless set above.
REQ-027 NOP accepted: ALU_OUT, ALU_OUT_HI, all flags 0; out_valid=1.
REQ-028 out_valid SHALL be high exactly one cycle per accepted op; outputs/flags hold last result until the next result is registered.
REQ-029 in_valid while in DIV SHALL be ignored; operand changes during DIV SHALL not affect the result (operands latched on accept).

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, in_ready=1, out_valid=0, ALU_OUT=0, ALU_OUT_HI=0, all flags 0; priority over any accept.
REQ-031 rst during DIV SHALL abort the division; no out_valid for it afterwards.

Verification (WIDTH=16)
REQ-032 Reset: rst=1 two cycles -> all outputs 0, in_ready=1, out_valid=0.
REQ-033 ADD A=0xD752 B=0x8B7C -> next cycle out_valid=1, ALU_OUT=0x62CE, carry=1, arith=1; back-to-back SUB 0x1234-0x5678 following cycle -> 0xBBBC, carry=1.
REQ-034 MUL 0x0100*0x0100 -> ALU_OUT=0x0000, ALU_OUT_HI=0x0001, carry=1; SHL A=0x0232 B=3 -> 0x1190, shift=1.
REQ-035 DIV 100/7 -> in_ready=0 for 16 cycles, out_valid 16 edges after accept, ALU_OUT=14, ALU_OUT_HI=2; in_valid pulses during DIV ignored.
REQ-036 DIV 0x1234/0 -> out_valid next cycle, ALU_OUT=0xFFFF, ALU_OUT_HI=0x1234, div_zero=1, in_ready stays 1.
REQ-037 rst on 5th DIV cycle -> next cycle in_ready=1, outputs 0, no out_valid over following 20 cycles.

Source files
------------

// File: rtl/alu_seq_param.sv
// Sequential parameterised ALU.
// Every operation except DIV with a nonzero divisor completes on its accepting edge.
// DIV runs a restoring shift-subtract loop that yields one quotient bit per cycle,
// so it takes WIDTH cycles in StDiv.
module alu_seq_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [WIDTH-1:0] ALU_OUT_HI,
    output logic             carry_flag,
    output logic             arith_flag,
    output logic             logic_flag,
    output logic             cmp_flag,
    output logic             shift_flag,
    output logic             div_zero_flag
);

    localparam int unsigned CntW = $clog2(WIDTH);

    // Flag vector layout: {carry, arith, logic, cmp, shift, div_zero}
    localparam logic [5:0] FlCarry = 6'b100000;
    localparam logic [5:0] FlArith = 6'b010000;
    localparam logic [5:0] FlLogic = 6'b001000;
    localparam logic [5:0] FlCmp   = 6'b000100;
    localparam logic [5:0] FlShift = 6'b000010;
    localparam logic [5:0] FlDivZ  = 6'b000001;

    typedef enum logic [0:0] {StIdle, StDiv} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [5:0]       flg_q, flg_d;

    logic [WIDTH-1:0]   op_lo, op_hi;
    logic [5:0]         op_flg;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     shamt;

    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;

    assign sum   = {1'b0, A} + {1'b0, B};
    assign prod  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign shamt = B[SHW-1:0];

    // Single-cycle result for the presented opcode (DIV here only covers B == 0)
    always_comb begin
        op_lo  = '0;
        op_hi  = '0;
        op_flg = '0;
        case (ALU_FUN)
            4'b0000: begin
                op_lo  = sum[WIDTH-1:0];
                op_flg = FlArith | (sum[WIDTH] ? FlCarry : 6'b0);
            end
            4'b0001: begin
                op_lo  = A - B;
                op_flg = FlArith | ((A < B) ? FlCarry : 6'b0);
            end
            4'b0010: begin
                op_lo  = prod[WIDTH-1:0];
                op_hi  = prod[2*WIDTH-1:WIDTH];
                op_flg = FlArith | ((|prod[2*WIDTH-1:WIDTH]) ? FlCarry : 6'b0);
            end
            4'b0011: begin
                op_lo  = '1;
                op_hi  = A;
                op_flg = FlArith | FlDivZ;
            end
            4'b0100: begin op_lo = A & B;    op_flg = FlLogic; end
            4'b0101: begin op_lo = A | B;    op_flg = FlLogic; end
            4'b0110: begin op_lo = ~(A & B); op_flg = FlLogic; end
            4'b0111: begin op_lo = ~(A | B); op_flg = FlLogic; end
            4'b1000: begin op_lo = A ^ B;    op_flg = FlLogic; end
            4'b1001: begin op_lo = ~(A ^ B); op_flg = FlLogic; end
            4'b1010: begin op_lo = (A == B) ? WIDTH'(1) : '0; op_flg = FlCmp; end
            4'b1011: begin op_lo = (A > B)  ? WIDTH'(2) : '0; op_flg = FlCmp; end
            4'b1100: begin op_lo = (A < B)  ? WIDTH'(3) : '0; op_flg = FlCmp; end
            4'b1101: begin op_lo = A >> shamt; op_flg = FlShift; end
            4'b1110: begin op_lo = A << shamt; op_flg = FlShift; end
            default: ;
        endcase
    end

    // One restoring-division step: bring down the next dividend bit, subtract if it fits
    always_comb begin
        trial  = {rem_q, dvd_q[WIDTH-1]};
        q_bit  = (trial >= {1'b0, dvs_q});
        rem_nx = q_bit ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        quo_nx = {dvd_q[WIDTH-2:0], q_bit};
    end

    // Next-state: accept in StIdle, iterate the divider in StDiv
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        vld_d   = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;
        flg_d   = flg_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (ALU_FUN == 4'b0011 && B != '0) begin
                        state_d = StDiv;
                        cnt_d   = '0;
                        dvd_d   = A;
                        dvs_d   = B;
                        rem_d   = '0;
                    end else begin
                        vld_d = 1'b1;
                        lo_d  = op_lo;
                        hi_d  = op_hi;
                        flg_d = op_flg;
                    end
                end
            end
            StDiv: begin
                dvd_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StIdle;
                    vld_d   = 1'b1;
                    lo_d    = quo_nx;
                    hi_d    = rem_nx;
                    flg_d   = FlArith;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset wins over any accept and aborts a division
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready      = (state_q == StIdle);
    assign out_valid     = vld_q;
    assign ALU_OUT       = lo_q;
    assign ALU_OUT_HI    = hi_q;
    assign carry_flag    = flg_q[5];
    assign arith_flag    = flg_q[4];
    assign logic_flag    = flg_q[3];
    assign cmp_flag      = flg_q[2];
    assign shift_flag    = flg_q[1];
    assign div_zero_flag = flg_q[0];

endmodule
